// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_port_arbiter: round-robin fetch/data front end driving a single-port memory
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adrs,
  output logic              if_rdy,
  output logic [DATA_W-1:0] if_dat,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adrs,
  input  logic [DATA_W-1:0] d_wdat,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdat,
  output logic              wea,
  output logic [ADDR_W-1:0] adrs,
  output logic [DATA_W-1:0] datIn,
  input  logic [DATA_W-1:0] datOut
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic              grant_d, grant_d_nx;   // 1 = data port owns the transaction
  logic              prio_d, prio_d_nx;     // 1 = data wins the next contention
  logic              is_store, is_store_nx;
  logic              pick_d;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              wea_nx, if_rdy_nx, d_rdy_nx;
  logic [ADDR_W-1:0] adrs_nx;
  logic [DATA_W-1:0] datin_nx, if_dat_nx, d_rdat_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_d  <= 1'b0;
      prio_d   <= 1'b1;
      is_store <= 1'b0;
      cnt      <= '0;
      wea      <= 1'b0;
      adrs     <= '0;
      datIn    <= '0;
      if_rdy   <= 1'b0;
      d_rdy    <= 1'b0;
      if_dat   <= '0;
      d_rdat   <= '0;
    end else begin
      state    <= state_nx;
      grant_d  <= grant_d_nx;
      prio_d   <= prio_d_nx;
      is_store <= is_store_nx;
      cnt      <= cnt_nx;
      wea      <= wea_nx;
      adrs     <= adrs_nx;
      datIn    <= datin_nx;
      if_rdy   <= if_rdy_nx;
      d_rdy    <= d_rdy_nx;
      if_dat   <= if_dat_nx;
      d_rdat   <= d_rdat_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    grant_d_nx  = grant_d;
    prio_d_nx   = prio_d;
    is_store_nx = is_store;
    cnt_nx      = cnt;
    pick_d      = 1'b0;
    wea_nx      = wea;
    adrs_nx     = adrs;
    datin_nx    = datIn;
    if_rdy_nx   = 1'b0;
    d_rdy_nx    = 1'b0;
    if_dat_nx   = if_dat;
    d_rdat_nx   = d_rdat;

    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          pick_d     = d_req && (!if_req || prio_d);
          grant_d_nx = pick_d;
          prio_d_nx  = !pick_d;
          state_nx   = ISSUE;
          if (pick_d) begin
            adrs_nx     = d_adrs;
            datin_nx    = d_wdat;
            wea_nx      = d_we;
            is_store_nx = d_we;
          end else begin
            adrs_nx     = if_adrs;
            wea_nx      = 1'b0;
            is_store_nx = 1'b0;
          end
        end
      end
      ISSUE: begin
        wea_nx = 1'b0;
        if (is_store) begin
          // Only the data port can store, so the store response is always d_rdy.
          state_nx = RESP;
          d_rdy_nx = 1'b1;
        end else begin
          state_nx = WAIT;
          cnt_nx   = CNT_W'(READ_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          if (grant_d) begin
            d_rdat_nx = datOut;
            d_rdy_nx  = 1'b1;
          end else begin
            if_dat_nx = datOut;
            if_rdy_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: directed and random traffic against a transaction-level model
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_adrs = '0;
  logic          if_rdy;
  logic [DW-1:0] if_dat;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_adrs = '0;
  logic [DW-1:0] d_wdat = '0;
  logic          d_rdy;
  logic [DW-1:0] d_rdat;
  logic          wea;
  logic [AW-1:0] adrs;
  logic [DW-1:0] datIn;
  logic [DW-1:0] datOut;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wea_cnt = 0;
  bit order[$];   // 1 = data response, 0 = fetch response

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_adrs(if_adrs), .if_rdy(if_rdy), .if_dat(if_dat),
    .d_req(d_req), .d_we(d_we), .d_adrs(d_adrs), .d_wdat(d_wdat),
    .d_rdy(d_rdy), .d_rdat(d_rdat),
    .wea(wea), .adrs(adrs), .datIn(datIn), .datOut(datOut)
  );

  // Memory with READ_LAT edges from address to data
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:RL-1];
  assign datOut = rd_pipe[RL-1];

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (wea) mem[adrs] <= datIn;
      rd_pipe[0] <= mem[adrs];
      for (int i = RL-1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Transaction-level model: each grant schedules its write edge, response edge
  // and next sampling edge as absolute edge numbers.
  int            m = 0;
  int            nxt = 0;
  int            w_edge = -1;
  int            r_edge = -1;
  bit            r_is_d = 1'b0;
  bit            r_rd = 1'b0;
  bit            prio_d = 1'b1;
  bit            take_d;
  bit            fresh = 1'b1;
  logic [DW-1:0] r_val = '0;
  logic          e_wea = 1'b0, e_if_rdy = 1'b0, e_d_rdy = 1'b0;
  logic [AW-1:0] e_adrs = '0;
  logic [DW-1:0] e_datin = '0, e_if_dat = '0, e_d_rdat = '0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e_wea = 0; e_if_rdy = 0; e_d_rdy = 0;
        e_adrs = '0; e_datin = '0; e_if_dat = '0; e_d_rdat = '0;
        nxt = m; w_edge = -1; r_edge = -1; prio_d = 1'b1; fresh = 1'b1;
      end else begin
        m++;
        if (m >= nxt && (if_req || d_req)) begin
          take_d = d_req && (!if_req || prio_d);
          prio_d = !take_d;
          fresh  = 1'b0;
          r_is_d = take_d;
          if (take_d && d_we) begin
            e_adrs = d_adrs; e_datin = d_wdat; ref_mem[d_adrs] = d_wdat;
            w_edge = m; r_edge = m + 1; r_rd = 1'b0;
          end else begin
            e_adrs = take_d ? d_adrs : if_adrs;
            r_val  = ref_mem[e_adrs];
            w_edge = -1; r_edge = m + RL + 1; r_rd = 1'b1;
          end
          nxt = r_edge + 2;
        end
        e_wea    = (m == w_edge);
        e_if_rdy = (m == r_edge) && !r_is_d;
        e_d_rdy  = (m == r_edge) && r_is_d;
        if (m == r_edge && r_rd) begin
          if (r_is_d) e_d_rdat = r_val;
          else        e_if_dat = r_val;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("wea", {31'd0, wea}, {31'd0, e_wea});
      chk("adrs", 32'(adrs), 32'(e_adrs));
      if (e_wea || fresh) chk("datIn", 32'(datIn), 32'(e_datin));
      chk("if_rdy", {31'd0, if_rdy}, {31'd0, e_if_rdy});
      chk("d_rdy", {31'd0, d_rdy}, {31'd0, e_d_rdy});
      chk("if_dat", 32'(if_dat), 32'(e_if_dat));
      chk("d_rdat", 32'(d_rdat), 32'(e_d_rdat));
      if (wea) wea_cnt++;
      if (d_rdy) order.push_back(1'b1);
      if (if_rdy) order.push_back(1'b0);
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that ends the rdy cycle.
  task automatic d_xact(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output logic [DW-1:0] rd, output int lat);
    int n = 0;
    int t0;
    d_req = 1'b1; d_we = we; d_adrs = a; d_wdat = wd; t0 = cyc;
    do begin @(negedge clk); n++; end while (!d_rdy && n < 60);
    tests++;
    if (!d_rdy) begin
      fails++;
      $display("FAIL d_handshake timeout at cycle %0d: got no d_rdy expected d_rdy", cyc);
    end
    rd = d_rdat; lat = cyc - t0;
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic i_xact(input logic [AW-1:0] a, output logic [DW-1:0] rd, output int lat);
    int n = 0;
    int t0;
    if_req = 1'b1; if_adrs = a; t0 = cyc;
    do begin @(negedge clk); n++; end while (!if_rdy && n < 60);
    tests++;
    if (!if_rdy) begin
      fails++;
      $display("FAIL if_handshake timeout at cycle %0d: got no if_rdy expected if_rdy", cyc);
    end
    rd = if_dat; lat = cyc - t0;
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] rd_d, rd_i;
  int            lat_d, lat_i, w0;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (10) @(posedge clk);
    #1;
    chk("idle_adrs", 32'(adrs), 32'd0);
    chk("idle_rdy", {30'd0, if_rdy, d_rdy}, 32'd0);

    w0 = wea_cnt;
    for (int i = 1; i <= 4; i++) begin
      d_xact(1'b1, AW'(i), DW'(i), rd_d, lat_d);
      chk("store_lat", 32'(lat_d), 32'd2);
    end
    chk("store_wea_cycles", 32'(wea_cnt - w0), 32'd4);

    for (int i = 0; i <= 4; i++) begin
      d_xact(1'b0, AW'(i), '0, rd_d, lat_d);
      chk("load_dat", 32'(rd_d), 32'(i));
      chk("load_lat", 32'(lat_d), 32'(RL + 2));
    end

    order.delete();
    i_xact(AW'(3), rd_i, lat_i);
    chk("fetch_dat", 32'(rd_i), 32'h0003);
    chk("fetch_lat", 32'(lat_i), 32'(RL + 2));
    chk("fetch_only_one_rdy", 32'(order.size()), 32'd1);
    if (order.size() > 0) chk("fetch_is_if", {31'd0, order[0]}, 32'd0);

    order.delete();
    fork
      begin
        for (int k = 0; k < 4; k++)
          d_xact(1'(k % 2), AW'(20 + k), DW'(16'h1100 + k), rd_d, lat_d);
      end
      begin
        for (int k = 0; k < 4; k++)
          i_xact(AW'(k + 1), rd_i, lat_i);
      end
    join
    chk("rr_count", 32'(order.size()), 32'd8);
    for (int k = 0; k < order.size() && k < 8; k++)
      chk("rr_order", {31'd0, order[k]}, {31'd0, (k % 2 == 0)});

    // Reset while a load sits in WAIT
    order.delete();
    d_req = 1'b1; d_we = 1'b0; d_adrs = AW'(2);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    chk("rst_adrs", 32'(adrs), 32'd0);
    chk("rst_d_rdat", 32'(d_rdat), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (RL + 4) @(posedge clk);
    #1;
    chk("aborted_no_rdy", 32'(order.size()), 32'd0);

    order.delete();
    fork
      d_xact(1'b1, AW'(9), 16'hBEEF, rd_d, lat_d);
      i_xact(AW'(9), rd_i, lat_i);
    join
    chk("first_contention_data", 32'(order.size() > 0 ? order[0] : 1'b0), 32'd1);
    chk("fetch_after_store", 32'(rd_i), 32'hBEEF);
    d_xact(1'b0, AW'(2), '0, rd_d, lat_d);
    chk("load_after_reset", 32'(rd_d), 32'h0002);

    fork
      begin
        int gd;
        for (int k = 0; k < 30; k++) begin
          gd = $urandom_range(0, 3);
          repeat (gd) begin @(posedge clk); #1; end
          d_xact(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), rd_d, lat_d);
        end
      end
      begin
        int gi;
        for (int k = 0; k < 30; k++) begin
          gi = $urandom_range(0, 3);
          repeat (gi) begin @(posedge clk); #1; end
          i_xact(AW'($urandom_range(0, 15)), rd_i, lat_i);
        end
      end
    join
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
